// File: rtl/rr_mux_4x1.sv
// Four-to-one valid/ready stream mux with round-robin arbitration and packet locking.
// Every output beat carries its source channel index on out_sel.
module rr_mux_4x1 #(
  parameter int unsigned DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            in_valid,
  input  logic [3:0]            in_last,
  input  logic [4*DATA_W-1:0]   in_data,
  output logic [3:0]            in_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last,
  output logic [1:0]            out_sel,
  input  logic                  out_ready
);

  localparam int unsigned N_CH  = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {ARB, LOCK} state_t;

  state_t             state, state_n;
  logic [SEL_W-1:0]   ptr, ptr_n;
  logic [SEL_W-1:0]   lock_ch, lock_ch_n;
  logic               load_en;
  logic               gnt_any;
  logic [SEL_W-1:0]   gnt_idx;
  logic               out_valid_n;
  logic [DATA_W-1:0]  out_data_n;
  logic               out_last_n;
  logic [SEL_W-1:0]   out_sel_n;
  logic [DATA_W-1:0]  ch_data [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*DATA_W +: DATA_W];
  end

  // State, pointer and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB;
      ptr       <= '0;
      lock_ch   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      lock_ch   <= lock_ch_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
      out_last  <= out_last_n;
      out_sel   <= out_sel_n;
    end
  end

  // Grant selection, next state and output-register load.
  always_comb begin
    logic [SEL_W-1:0] cand;
    state_n     = state;
    ptr_n       = ptr;
    lock_ch_n   = lock_ch;
    gnt_any     = 1'b0;
    gnt_idx     = ptr;
    cand        = ptr;
    in_ready    = '0;
    load_en     = !out_valid || out_ready;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    out_last_n  = out_last;
    out_sel_n   = out_sel;

    if (state == ARB) begin
      for (int k = 0; k < N_CH; k++) begin
        cand = ptr + SEL_W'(k);
        if (!gnt_any && in_valid[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end else if (in_valid[lock_ch]) begin
      gnt_any = 1'b1;
      gnt_idx = lock_ch;
    end

    // No grant while in reset or while the output register is stalled.
    if (!load_en || !rst_n) begin
      gnt_any = 1'b0;
    end

    if (gnt_any) begin
      in_ready[gnt_idx] = 1'b1;
      out_valid_n       = 1'b1;
      out_data_n        = ch_data[gnt_idx];
      out_last_n        = in_last[gnt_idx];
      out_sel_n         = gnt_idx;
      if (in_last[gnt_idx]) begin
        state_n = ARB;
        ptr_n   = gnt_idx + SEL_W'(1);
      end else begin
        state_n   = LOCK;
        lock_ch_n = gnt_idx;
      end
    end else if (out_valid && out_ready) begin
      out_valid_n = 1'b0;
    end
  end

endmodule
